// File: rtl/k_alu_issue_ctrl.sv
// Execute-stage sequencer for a combinational 32-bit ALU. It takes one instruction at a time,
// reads its operands from an internal register file, captures the ALU result and writes it back.
// Latency: accept edge t -> out_valid high from edge t+2 (seen at edge t+3); accepts are at least 4 cycles apart.
// Backpressure: in_ready is high only in IDLE. While out_ready is low, the result is held in WB with no loss.
//
// Ports: clk/rst (async active-high); in_* instruction channel (valid/ready); alu_a/alu_b/alu_sel
// drive the external ALU and alu_res returns its result; out_* retired-result channel (valid/ready);
// dbg_addr/dbg_data give a combinational register-file read port (r0 reads as 0).
module k_alu_issue_ctrl #(
    parameter int DATA_W = 32,
    parameter int NREG   = 16,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_func,
    input  logic [REG_AW-1:0] in_rs,
    input  logic [REG_AW-1:0] in_rt,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_use_imm,
    input  logic              in_li,
    input  logic [15:0]       in_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_res,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] out_rd,
    output logic [DATA_W-1:0] out_data,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t              state_q, state_d;
    logic [3:0]          func_q, func_d;
    logic [REG_AW-1:0]   rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic                use_imm_q, use_imm_d, li_q, li_d;
    logic [15:0]         imm_q, imm_d;
    // Operand and select registers feed the ALU pins directly. Because they are loaded only
    // on the READ->EXEC edge, they stay stable through EXEC and keep their value afterwards.
    logic [DATA_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]          alu_sel_q, alu_sel_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   regs_q [NREG];
    logic [DATA_W-1:0]   regs_d [NREG];

    logic [DATA_W-1:0]   imm_sext, rs_val, rt_val;

    assign imm_sext = {{(DATA_W-16){imm_q[15]}}, imm_q};
    assign rs_val   = (rs_q == '0) ? '0 : regs_q[rs_q];
    assign rt_val   = (rt_q == '0) ? '0 : regs_q[rt_q];

    // in_ready is gated by rst so that no handshake appears while reset is held.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign out_valid = out_valid_q;
    assign out_rd    = rd_q;
    assign out_data  = res_q;
    assign dbg_data  = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

    always_comb begin
        state_d     = state_q;
        func_d      = func_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        rd_d        = rd_q;
        use_imm_d   = use_imm_q;
        li_d        = li_q;
        imm_d       = imm_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;
        regs_d      = regs_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    func_d    = in_func;
                    rs_d      = in_rs;
                    rt_d      = in_rt;
                    rd_d      = in_rd;
                    use_imm_d = in_use_imm;
                    li_d      = in_li;
                    imm_d     = in_imm;
                    state_d   = READ;
                end
            end
            READ: begin
                alu_a_d   = rs_val;
                alu_b_d   = use_imm_q ? imm_sext : rt_val;
                alu_sel_d = func_q;
                state_d   = EXEC;
            end
            EXEC: begin
                res_d       = li_q ? imm_sext : alu_res;
                out_valid_d = 1'b1;
                state_d     = WB;
            end
            WB: begin
                if (out_ready) begin
                    // A destination of r0 still retires on the output port but leaves the file untouched.
                    if (rd_q != '0) begin
                        regs_d[rd_q] = res_q;
                    end
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            func_q      <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            use_imm_q   <= 1'b0;
            li_q        <= 1'b0;
            imm_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            func_q      <= func_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            use_imm_q   <= use_imm_d;
            li_q        <= li_d;
            imm_q       <= imm_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            regs_q      <= regs_d;
        end
    end

endmodule

// File: tb/tb_k_alu_issue_ctrl.sv
module tb_k_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_func = '0;
    logic [3:0]  in_rs = '0, in_rt = '0, in_rd = '0;
    logic        in_use_imm = 1'b0, in_li = 1'b0;
    logic [15:0] in_imm = '0;
    logic [31:0] alu_a, alu_b, alu_res;
    logic [3:0]  alu_sel;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_rd;
    logic [31:0] out_data;
    logic [3:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    int vectors = 0;
    int miscompares = 0;

    // Reference state: architectural register contents and the queue of retirements still expected.
    logic [31:0] model [16];
    logic [35:0] exp_q [$];

    always #5 clk = ~clk;

    // Stub ALU: add for select 0010, xor otherwise.
    assign alu_res = (alu_sel == 4'b0010) ? alu_a + alu_b : alu_a ^ alu_b;

    k_alu_issue_ctrl #(.DATA_W(32), .NREG(16), .REG_AW(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_use_imm(in_use_imm), .in_li(in_li), .in_imm(in_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_res(alu_res),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_data(out_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] sext(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    // Monitor: every output handshake retires the oldest expected result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_retire", 32'd1, 32'd0);
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                chk("out_rd", {28'd0, out_rd}, {28'd0, e[35:32]});
                chk("out_data", out_data, e[31:0]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_reg(input logic [3:0] a);
        dbg_addr = a;
        #1;
        chk($sformatf("dbg_r%0d", a), dbg_data, model[a]);
    endtask

    // Issue one instruction and follow it through READ/EXEC to WB. The task returns at the
    // WB negedge. When rst_exec is set, reset is asserted during EXEC and nothing retires.
    task automatic issue(input logic [3:0] f, input logic [3:0] rs, input logic [3:0] rt,
                         input logic [3:0] rd, input logic ui, input logic li,
                         input logic [15:0] imm, input bit rst_exec);
        int n;
        logic [31:0] a, b, r;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b1; in_func = f; in_rs = rs; in_rt = rt; in_rd = rd;
        in_use_imm = ui; in_li = li; in_imm = imm;
        a = model[rs];
        b = ui ? sext(imm) : model[rt];
        r = li ? sext(imm) : ((f == 4'b0010) ? a + b : a ^ b);
        if (!rst_exec) begin
            exp_q.push_back({rd, r});
            if (rd != 4'd0) model[rd] = r;
        end
        @(posedge clk);
        #1;
        // Scramble the inputs after acceptance; the controller must not depend on them being held.
        in_valid = 1'b0; in_func = 4'($urandom); in_rs = 4'($urandom); in_rt = 4'($urandom);
        in_rd = 4'($urandom); in_imm = 16'($urandom);
        @(negedge clk);
        chk("read_out_valid", {31'd0, out_valid}, 32'd0);
        chk("read_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("exec_alu_a", alu_a, a);
        chk("exec_alu_b", alu_b, b);
        chk("exec_alu_sel", {28'd0, alu_sel}, {28'd0, f});
        chk("exec_out_valid", {31'd0, out_valid}, 32'd0);
        if (rst_exec) begin
            rst = 1'b1;
            #1;
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < 16; i++) model[i] = 32'd0;
            #1;
            chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        end else begin
            @(negedge clk);
            chk("wb_latency_out_valid", {31'd0, out_valid}, 32'd1);
        end
    endtask

    // Let the WB handshake happen, then read the destination back from the next cycle.
    task automatic retire_and_check(input logic [3:0] rd);
        @(posedge clk);
        @(negedge clk);
        check_reg(rd);
    endtask

    initial begin
        logic [31:0] held, old5;
        for (int i = 0; i < 16; i++) model[i] = 32'd0;

        // Power-on reset state.
        #2;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
        chk("reset_alu_a", alu_a, 32'd0);
        chk("reset_out_data", out_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);

        // Load immediates.
        issue(4'b0000, 4'd0, 4'd0, 4'd1, 1'b1, 1'b1, 16'd123, 1'b0);
        retire_and_check(4'd1);
        issue(4'b0000, 4'd0, 4'd0, 4'd2, 1'b1, 1'b1, 16'd78, 1'b0);
        retire_and_check(4'd2);

        // Register-register add: r3 = 123 + 78.
        issue(4'b0010, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 16'd0, 1'b0);
        retire_and_check(4'd3);
        chk("r3_is_201", model[3], 32'd201);

        // Immediate add with a negative immediate: r4 = 123 + (-1).
        issue(4'b0010, 4'd1, 4'd0, 4'd4, 1'b1, 1'b0, 16'hFFFF, 1'b0);
        retire_and_check(4'd4);
        chk("r4_is_122", model[4], 32'd122);

        // Backpressure: hold out_ready low for 5 cycles in WB.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        old5 = model[5];
        issue(4'b0010, 4'd3, 4'd4, 4'd5, 1'b0, 1'b0, 16'd0, 1'b0);
        held = out_data;
        chk("stall_data_value", held, 32'd323);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_out_data", out_data, held);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            dbg_addr = 4'd5;
            #1;
            chk("stall_r5_unchanged", dbg_data, old5);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        retire_and_check(4'd5);

        // Write to r0: still retires, but r0 keeps reading 0.
        issue(4'b0000, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 16'd55, 1'b0);
        retire_and_check(4'd0);

        // Reset while an instruction is in EXEC: it is dropped and the file is cleared.
        issue(4'b0010, 4'd1, 4'd2, 4'd6, 1'b0, 1'b0, 16'd0, 1'b1);
        @(negedge clk);
        check_reg(4'd1);
        check_reg(4'd6);
        chk("dropped_queue_empty", exp_q.size(), 32'd0);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 40; k++) begin
            logic [3:0] f;
            f = ($urandom_range(0, 1) == 0) ? 4'b0010 : 4'($urandom);
            issue(f, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0), 16'($urandom), 1'b0);
        end
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 16; i++) check_reg(4'(i));

        // Mid-simulation reset while idle.
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1;
            chk("midrst_dbg_zero", dbg_data, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 32'd0;
        #1;
        chk("midrst_release_in_ready", {31'd0, in_ready}, 32'd1);

        // Operation after reset: r7 = 0 ^ sext(8000).
        issue(4'b0111, 4'd7, 4'd0, 4'd7, 1'b1, 1'b0, 16'h8000, 1'b0);
        retire_and_check(4'd7);

        @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
